// File: rtl/player_ship_ctrl.sv
// Player ship controller: position, lives, shot issue and the
// RUN / HIT / DEAD sequencing. Motion and all timers advance on the
// per-frame tick; every output comes straight from a register (or a
// constant offset of one), so each is one clock behind its cause.
module player_ship_ctrl #(
  parameter int             width_p        = 10,
  parameter int             left_border_p  = 9,
  parameter int             right_border_p = 630,
  parameter int             ship_width_p   = 35,
  parameter int             start_pos_p    = 249,
  parameter int             step_p         = 10,
  parameter int             max_lives_p    = 3,
  parameter int             init_lives_p   = 2,
  parameter int             cooldown_p     = 8,
  parameter int             hold_ticks_p   = 60,
  parameter int             flash_period_p = 8,
  parameter logic [11:0]    color_p        = 12'h5E5
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic                                 frame_tick_i,
  input  logic                                 move_left_i,
  input  logic                                 move_right_i,
  input  logic                                 shoot_i,
  input  logic                                 bullet_active_i,
  input  logic                                 hit_i,
  input  logic                                 add_life_i,
  output logic                                 alive_o,
  output logic                                 shot_laser_o,
  output logic                                 resume_o,
  output logic                                 new_game_o,
  output logic [width_p-1:0]                   pos_left_o,
  output logic [width_p-1:0]                   pos_right_o,
  output logic [width_p-1:0]                   gun_pos_o,
  output logic [$clog2(max_lives_p+1)-1:0]     lives_o,
  output logic                                 visible_o,
  output logic [1:0]                           state_o,
  output logic [3:0]                           red_o,
  output logic [3:0]                           green_o,
  output logic [3:0]                           blue_o
);

  localparam int lives_w_lp = $clog2(max_lives_p + 1);
  localparam int cool_w_lp  = $clog2(cooldown_p + 1);
  localparam int hold_w_lp  = $clog2(hold_ticks_p + 1);
  localparam int flash_w_lp = $clog2(flash_period_p + 1);

  typedef logic [width_p-1:0]  pos_t;
  typedef logic [width_p:0]    pos_ext_t;   // one spare bit so sums never wrap
  typedef logic [lives_w_lp-1:0] lives_t;
  typedef logic [lives_w_lp:0]   lives_ext_t;
  typedef logic [cool_w_lp-1:0]  cool_t;
  typedef logic [hold_w_lp-1:0]  hold_t;
  typedef logic [flash_w_lp-1:0] flash_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HIT  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  localparam pos_ext_t   left_x_lp     = pos_ext_t'(left_border_p);
  localparam pos_ext_t   right_lim_lp  = pos_ext_t'(right_border_p - ship_width_p);
  localparam pos_ext_t   step_x_lp     = pos_ext_t'(step_p);
  localparam pos_t       start_lp      = pos_t'(start_pos_p);
  localparam pos_t       ship_w_lp     = pos_t'(ship_width_p);
  localparam pos_t       gun_off_lp    = pos_t'(ship_width_p / 2);
  localparam lives_t     max_l_lp      = lives_t'(max_lives_p);
  localparam lives_ext_t max_lx_lp     = lives_ext_t'(max_lives_p);
  localparam lives_t     init_l_lp     = lives_t'(init_lives_p);
  localparam cool_t      cool_load_lp  = cool_t'(cooldown_p);
  localparam hold_t      hold_max_lp   = hold_t'(hold_ticks_p);
  localparam flash_t     flash_last_lp = flash_t'(flash_period_p - 1);

  state_t state_reg, state_next;
  pos_t   pos_reg, pos_next;
  lives_t lives_reg, lives_next;
  cool_t  cool_reg, cool_next;
  hold_t  hold_reg, hold_next;
  flash_t flash_reg, flash_next;
  logic   vis_reg, vis_next;
  logic   shoot_q_reg;
  logic   shot_reg, shot_next;
  logic   resume_reg, resume_next;
  logic   new_game_reg, new_game_next;

  logic       shoot_edge;
  pos_ext_t   pos_ext;
  pos_ext_t   pos_move;
  lives_ext_t lives_plus;
  lives_ext_t lives_hit;
  lives_t     lives_inc;

  assign shoot_edge = shoot_i & ~shoot_q_reg;
  assign pos_ext    = {1'b0, pos_reg};
  assign lives_plus = {1'b0, lives_reg} + {{lives_w_lp{1'b0}}, add_life_i};
  assign lives_hit  = (lives_plus - 1'b1 > max_lx_lp) ? max_lx_lp : lives_plus - 1'b1;
  assign lives_inc  = (lives_reg == max_l_lp) ? lives_reg : lives_reg + 1'b1;

  // Clamped horizontal move; borders are compared before any subtraction.
  always_comb begin
    pos_move = pos_ext;
    if (move_left_i && !move_right_i) begin
      pos_move = (pos_ext < left_x_lp + step_x_lp) ? left_x_lp : pos_ext - step_x_lp;
    end else if (move_right_i && !move_left_i) begin
      pos_move = (pos_ext + step_x_lp > right_lim_lp) ? right_lim_lp : pos_ext + step_x_lp;
    end
  end

  // Next-state and next-register values for the RUN / HIT / DEAD machine.
  always_comb begin
    state_next    = state_reg;
    pos_next      = pos_reg;
    lives_next    = lives_reg;
    cool_next     = cool_reg;
    hold_next     = hold_reg;
    flash_next    = flash_reg;
    vis_next      = vis_reg;
    shot_next     = 1'b0;
    resume_next   = 1'b0;
    new_game_next = 1'b0;

    // Shot cooldown runs down in every state; loads below take priority.
    if (frame_tick_i && cool_reg != '0) begin
      cool_next = cool_reg - 1'b1;
    end

    case (state_reg)
      ST_RUN: begin
        vis_next = 1'b1;
        if (hit_i) begin
          // The bonus life in the hit cycle is folded into the hit.
          if (lives_plus == '0) begin
            state_next = ST_DEAD;
            lives_next = '0;
            vis_next   = 1'b0;
          end else begin
            state_next = ST_HIT;
            lives_next = lives_hit[lives_w_lp-1:0];
            hold_next  = '0;
            flash_next = '0;
          end
        end else begin
          if (add_life_i) begin
            lives_next = lives_inc;
          end
          if (frame_tick_i) begin
            pos_next = pos_move[width_p-1:0];
          end
          if (shoot_edge && cool_reg == '0 && !bullet_active_i) begin
            shot_next = 1'b1;
            cool_next = cool_load_lp;
          end
        end
      end

      ST_HIT: begin
        if (add_life_i) begin
          lives_next = lives_inc;
        end
        if (shoot_edge && hold_reg == hold_max_lp) begin
          state_next  = ST_RUN;
          pos_next    = start_lp;
          vis_next    = 1'b1;
          resume_next = 1'b1;
        end else if (frame_tick_i) begin
          if (hold_reg != hold_max_lp) begin
            hold_next = hold_reg + 1'b1;
          end
          if (flash_reg == flash_last_lp) begin
            flash_next = '0;
            vis_next   = ~vis_reg;
          end else begin
            flash_next = flash_reg + 1'b1;
          end
        end
      end

      ST_DEAD: begin
        vis_next = 1'b0;
        if (shoot_edge) begin
          state_next    = ST_RUN;
          lives_next    = init_l_lp;
          pos_next      = start_lp;
          cool_next     = '0;
          vis_next      = 1'b1;
          new_game_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_reg    <= ST_RUN;
      pos_reg      <= start_lp;
      lives_reg    <= init_l_lp;
      cool_reg     <= '0;
      hold_reg     <= '0;
      flash_reg    <= '0;
      vis_reg      <= 1'b1;
      shoot_q_reg  <= 1'b0;
      shot_reg     <= 1'b0;
      resume_reg   <= 1'b0;
      new_game_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pos_reg      <= pos_next;
      lives_reg    <= lives_next;
      cool_reg     <= cool_next;
      hold_reg     <= hold_next;
      flash_reg    <= flash_next;
      vis_reg      <= vis_next;
      shoot_q_reg  <= shoot_i;
      shot_reg     <= shot_next;
      resume_reg   <= resume_next;
      new_game_reg <= new_game_next;
    end
  end

  assign alive_o      = (state_reg != ST_DEAD);
  assign shot_laser_o = shot_reg;
  assign resume_o     = resume_reg;
  assign new_game_o   = new_game_reg;
  assign pos_left_o   = pos_reg;
  assign pos_right_o  = pos_reg + ship_w_lp;
  assign gun_pos_o    = pos_reg + gun_off_lp;
  assign lives_o      = lives_reg;
  assign visible_o    = vis_reg;
  assign state_o      = state_reg;
  assign red_o        = vis_reg ? color_p[11:8] : 4'h0;
  assign green_o      = vis_reg ? color_p[7:4]  : 4'h0;
  assign blue_o       = vis_reg ? color_p[3:0]  : 4'h0;

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Bench for player_ship_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural game model.
module tb_player_ship_ctrl;

  localparam int LEFT  = 9;
  localparam int RIGHT = 630;
  localparam int SHIPW = 35;
  localparam int START = 249;
  localparam int STEP  = 10;
  localparam int MAXL  = 3;
  localparam int INITL = 2;
  localparam int COOL  = 8;
  localparam int HOLD  = 60;
  localparam int FLASH = 8;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic frame_tick_i = 1'b0, move_left_i = 1'b0, move_right_i = 1'b0;
  logic shoot_i = 1'b0, bullet_active_i = 1'b0, hit_i = 1'b0, add_life_i = 1'b0;
  logic alive_o, shot_laser_o, resume_o, new_game_o, visible_o;
  logic [9:0] pos_left_o, pos_right_o, gun_pos_o;
  logic [1:0] lives_o, state_o;
  logic [3:0] red_o, green_o, blue_o;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 RUN, 1 HIT, 2 DEAD
  int  m_mode, m_pos, m_lives, m_cool, m_hit_ticks;
  bit  m_shoot_prev, m_shot, m_resume, m_newgame;

  always #5 clk = ~clk;

  player_ship_ctrl dut (
    .clk_i(clk), .reset_ni(reset_ni), .frame_tick_i(frame_tick_i),
    .move_left_i(move_left_i), .move_right_i(move_right_i), .shoot_i(shoot_i),
    .bullet_active_i(bullet_active_i), .hit_i(hit_i), .add_life_i(add_life_i),
    .alive_o(alive_o), .shot_laser_o(shot_laser_o), .resume_o(resume_o),
    .new_game_o(new_game_o), .pos_left_o(pos_left_o), .pos_right_o(pos_right_o),
    .gun_pos_o(gun_pos_o), .lives_o(lives_o), .visible_o(visible_o),
    .state_o(state_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Game rules applied to the inputs present at the clock edge.
  task automatic model_step();
    bit edge_s;
    int cool_n;
    edge_s = shoot_i && !m_shoot_prev;
    m_shot = 0; m_resume = 0; m_newgame = 0;
    if (!reset_ni) begin
      m_mode = 0; m_pos = START; m_lives = INITL; m_cool = 0;
      m_hit_ticks = 0; m_shoot_prev = 0;
      return;
    end
    m_shoot_prev = shoot_i;
    cool_n = (frame_tick_i && m_cool > 0) ? m_cool - 1 : m_cool;
    if (m_mode == 0) begin
      if (hit_i) begin
        if (m_lives + int'(add_life_i) == 0) begin
          m_mode = 2; m_lives = 0;
        end else begin
          m_mode = 1; m_lives = imin(m_lives + int'(add_life_i) - 1, MAXL);
          m_hit_ticks = 0;
        end
      end else begin
        m_lives = imin(m_lives + int'(add_life_i), MAXL);
        if (frame_tick_i && move_left_i && !move_right_i)  m_pos = imax(LEFT, m_pos - STEP);
        if (frame_tick_i && move_right_i && !move_left_i)  m_pos = imin(RIGHT - SHIPW, m_pos + STEP);
        if (edge_s && m_cool == 0 && !bullet_active_i) begin
          m_shot = 1; cool_n = COOL;
        end
      end
    end else if (m_mode == 1) begin
      m_lives = imin(m_lives + int'(add_life_i), MAXL);
      if (edge_s && imin(m_hit_ticks, HOLD) == HOLD) begin
        m_mode = 0; m_pos = START; m_resume = 1;
      end else if (frame_tick_i) begin
        m_hit_ticks++;
      end
    end else begin
      if (edge_s) begin
        m_mode = 0; m_lives = INITL; m_pos = START; cool_n = 0; m_newgame = 1;
      end
    end
    m_cool = cool_n;
  endtask

  // One clock: update model at the edge, compare all outputs 1 time unit later.
  task automatic step();
    bit vis;
    @(posedge clk);
    model_step();
    #1;
    vis = (m_mode == 0) ? 1'b1 : (m_mode == 2) ? 1'b0 : (((m_hit_ticks / FLASH) % 2) == 0);
    check_val("state",    int'(state_o),      m_mode);
    check_val("pos_left", int'(pos_left_o),   m_pos);
    check_val("pos_right",int'(pos_right_o),  m_pos + SHIPW);
    check_val("gun_pos",  int'(gun_pos_o),    m_pos + SHIPW / 2);
    check_val("lives",    int'(lives_o),      m_lives);
    check_val("visible",  int'(visible_o),    int'(vis));
    check_val("alive",    int'(alive_o),      int'(m_mode != 2));
    check_val("shot",     int'(shot_laser_o), int'(m_shot));
    check_val("resume",   int'(resume_o),     int'(m_resume));
    check_val("new_game", int'(new_game_o),   int'(m_newgame));
    check_val("red",      int'(red_o),        vis ? 5  : 0);
    check_val("green",    int'(green_o),      vis ? 14 : 0);
    check_val("blue",     int'(blue_o),       vis ? 5  : 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick_i = 1'b1; step();
      frame_tick_i = 1'b0; step();
    end
  endtask

  task automatic press_shoot();
    shoot_i = 1'b0; step();
    shoot_i = 1'b1; step();
    shoot_i = 1'b0; step();
  endtask

  task automatic pulse_hit(input bit with_life);
    hit_i = 1'b1; add_life_i = with_life; step();
    hit_i = 1'b0; add_life_i = 1'b0; step();
  endtask

  task automatic resume_seq();
    ticks(HOLD + 1);
    press_shoot();
  endtask

  initial begin
    m_mode = 0; m_pos = START; m_lives = INITL; m_cool = 0;
    m_hit_ticks = 0; m_shoot_prev = 0;

    reset_ni = 1'b0; shoot_i = 1'b1;
    step(); step();
    reset_ni = 1'b1; shoot_i = 1'b0; step();
    $display("reset done: pos %0d lives %0d state %0d", pos_left_o, lives_o, state_o);

    move_left_i = 1'b1; ticks(30); move_left_i = 1'b0;
    $display("left sweep: pos %0d", pos_left_o);
    move_right_i = 1'b1; ticks(65);
    $display("right sweep: pos %0d right %0d", pos_left_o, pos_right_o);
    move_left_i = 1'b1; ticks(5); move_left_i = 1'b0; move_right_i = 1'b0;
    $display("both pressed: pos %0d", pos_left_o);

    shoot_i = 1'b1; ticks(20); shoot_i = 1'b0; ticks(10);
    $display("held shoot done");
    press_shoot(); ticks(3); press_shoot(); ticks(8); press_shoot();
    ticks(10); bullet_active_i = 1'b1; press_shoot(); bullet_active_i = 1'b0;
    $display("cooldown and bullet_active shots done");

    pulse_hit(1'b0); ticks(30); press_shoot(); ticks(31); press_shoot();
    $display("hit and resume: lives %0d state %0d", lives_o, state_o);
    pulse_hit(1'b0); resume_seq(); pulse_hit(1'b0);
    $display("death: state %0d alive %0d", state_o, alive_o);
    hit_i = 1'b1; add_life_i = 1'b1; step(); hit_i = 1'b0; add_life_i = 1'b0;
    press_shoot();
    $display("new game: lives %0d state %0d", lives_o, state_o);

    pulse_hit(1'b0); resume_seq(); pulse_hit(1'b0); resume_seq();
    pulse_hit(1'b1);
    $display("hit with bonus at zero lives: lives %0d state %0d", lives_o, state_o);
    resume_seq();
    for (int i = 0; i < 3; i++) begin
      add_life_i = 1'b1; step(); add_life_i = 1'b0; step();
    end
    $display("bonus lives: lives %0d", lives_o);
    pulse_hit(1'b0); ticks(12);
    reset_ni = 1'b0; step(); reset_ni = 1'b1; step();
    $display("reset in HIT: state %0d lives %0d", state_o, lives_o);

    for (int i = 0; i < 6000; i++) begin
      frame_tick_i    = ($urandom % 2) == 0;
      move_left_i     = ($urandom % 3) == 0;
      move_right_i    = ($urandom % 3) == 0;
      if (($urandom % 4) == 0) shoot_i = ~shoot_i;
      bullet_active_i = ($urandom % 4) == 0;
      hit_i           = ($urandom % 150) == 0;
      add_life_i      = ($urandom % 80) == 0;
      reset_ni        = ($urandom % 1500) != 0;
      step();
    end
    reset_ni = 1'b1;
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
